// File: rtl/payment_collector.sv
// Coin-accepting payment FSM: accumulates credit, vends with change, or refunds.
// Optional idle auto-refund is enabled by defining PAYMENT_TIMEOUT_EN.
module payment_collector #(
  parameter int COIN_VAL0      = 5,
  parameter int COIN_VAL1      = 10,
  parameter int COIN_VAL2      = 50,
  parameter int COIN_VAL3      = 100,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coin_valid,
  input  logic [1:0]  coin_type,
  input  logic        buy,
  input  logic        cancel,
  input  logic [15:0] price_due,
  output logic [15:0] amount_paid,
  output logic        vend,
  output logic        refund,
  output logic [15:0] change,
  output logic        change_valid,
  output logic        insufficient,
  output logic        coin_reject,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

  state_t      state, state_n;
  logic [15:0] paid_n, change_n, price_q, price_n, coin_value;
  logic [16:0] sum;
  logic        vend_n, refund_n, change_valid_n, insufficient_n, coin_reject_n, busy_n;
  logic        credited;
`ifdef PAYMENT_TIMEOUT_EN
  logic [31:0] idle_cnt, idle_cnt_n;
`endif

  always_comb begin
    coin_value = 16'(COIN_VAL0);
    case (coin_type)
      2'd0: coin_value = 16'(COIN_VAL0);
      2'd1: coin_value = 16'(COIN_VAL1);
      2'd2: coin_value = 16'(COIN_VAL2);
      2'd3: coin_value = 16'(COIN_VAL3);
      default: coin_value = 16'(COIN_VAL0);
    endcase
  end

  assign sum = {1'b0, amount_paid} + {1'b0, coin_value};

  // Change is formed from the price latched at the buy edge, so it is already valid in the VEND cycle
  always_comb begin
    state_n        = state;
    paid_n         = amount_paid;
    change_n       = change;
    price_n        = price_q;
    vend_n         = 1'b0;
    refund_n       = 1'b0;
    change_valid_n = 1'b0;
    insufficient_n = 1'b0;
    coin_reject_n  = 1'b0;
    busy_n         = 1'b0;
    credited       = 1'b0;
`ifdef PAYMENT_TIMEOUT_EN
    idle_cnt_n     = 32'd0;
`endif
    case (state)
      IDLE: begin
        if (coin_valid) begin
          paid_n  = coin_value;
          state_n = COLLECT;
        end
        if (buy) insufficient_n = 1'b1;
      end
      COLLECT: begin
        if (cancel) begin
          state_n        = REFUND;
          refund_n       = 1'b1;
          change_valid_n = 1'b1;
          change_n       = amount_paid;
          busy_n         = 1'b1;
          coin_reject_n  = coin_valid;
        end else if (buy) begin
          coin_reject_n = coin_valid;
          if (amount_paid >= price_due) begin
            state_n        = VEND;
            price_n        = price_due;
            vend_n         = 1'b1;
            change_valid_n = 1'b1;
            change_n       = amount_paid - price_due;
            busy_n         = 1'b1;
          end else begin
            insufficient_n = 1'b1;
          end
        end else if (coin_valid) begin
          if (sum[16]) begin
            coin_reject_n = 1'b1;
          end else begin
            paid_n   = sum[15:0];
            credited = 1'b1;
          end
        end
`ifdef PAYMENT_TIMEOUT_EN
        if (state_n == COLLECT && !credited) begin
          if (idle_cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
            state_n        = REFUND;
            refund_n       = 1'b1;
            change_valid_n = 1'b1;
            change_n       = amount_paid;
            busy_n         = 1'b1;
          end else begin
            idle_cnt_n = idle_cnt + 32'd1;
          end
        end
`endif
      end
      VEND, REFUND: begin
        paid_n        = 16'd0;
        state_n       = IDLE;
        coin_reject_n = coin_valid;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      amount_paid  <= 16'd0;
      change       <= 16'd0;
      price_q      <= 16'd0;
      vend         <= 1'b0;
      refund       <= 1'b0;
      change_valid <= 1'b0;
      insufficient <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
`ifdef PAYMENT_TIMEOUT_EN
      idle_cnt     <= 32'd0;
`endif
    end else begin
      state        <= state_n;
      amount_paid  <= paid_n;
      change       <= change_n;
      price_q      <= price_n;
      vend         <= vend_n;
      refund       <= refund_n;
      change_valid <= change_valid_n;
      insufficient <= insufficient_n;
      coin_reject  <= coin_reject_n;
      busy         <= busy_n;
`ifdef PAYMENT_TIMEOUT_EN
      idle_cnt     <= idle_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_payment_collector.sv
// Directed-vector bench for payment_collector (default build, PAYMENT_TIMEOUT_EN undefined).
module tb_payment_collector;

  logic        clk = 1'b0;
  logic        reset, coin_valid, buy, cancel;
  logic [1:0]  coin_type;
  logic [15:0] price_due;
  logic [15:0] amount_paid, change;
  logic        vend, refund, change_valid, insufficient, coin_reject, busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  payment_collector dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .buy(buy), .cancel(cancel), .price_due(price_due), .amount_paid(amount_paid),
    .vend(vend), .refund(refund), .change(change), .change_valid(change_valid),
    .insufficient(insufficient), .coin_reject(coin_reject), .busy(busy)
  );

  // Output bundle: paid, vend, refund, change, change_valid, insufficient, coin_reject, busy
  typedef struct packed {
    logic [15:0] paid;
    logic        vend;
    logic        refund;
    logic [15:0] chg;
    logic        cv;
    logic        insuf;
    logic        rej;
    logic        busy;
  } outs_t;

  typedef struct {
    logic        rst;
    logic        cv;
    logic [1:0]  ct;
    logic        buy;
    logic        cancel;
    logic [15:0] price;
    outs_t       exp;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic cv, input logic [1:0] ct,
                              input logic b, input logic c, input logic [15:0] p,
                              input logic [15:0] paid, input logic v, input logic r,
                              input logic [15:0] chg, input logic chv, input logic ins,
                              input logic rej, input logic bsy);
    vec_t t;
    t.rst = rst; t.cv = cv; t.ct = ct; t.buy = b; t.cancel = c; t.price = p;
    t.exp = '{paid: paid, vend: v, refund: r, chg: chg, cv: chv, insuf: ins, rej: rej, busy: bsy};
    return t;
  endfunction

  task automatic applyStimulus(input logic rst, input logic cv, input logic [1:0] ct,
                               input logic b, input logic c, input logic [15:0] p);
    reset = rst; coin_valid = cv; coin_type = ct; buy = b; cancel = c; price_due = p;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = '{paid: amount_paid, vend: vend, refund: refund, chg: change, cv: change_valid,
            insuf: insufficient, rej: coin_reject, busy: busy};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got paid=%h vend=%b refund=%b change=%h cv=%b insuf=%b rej=%b busy=%b, want paid=%h vend=%b refund=%b change=%h cv=%b insuf=%b rej=%b busy=%b",
               name, act.paid, act.vend, act.refund, act.chg, act.cv, act.insuf, act.rej, act.busy,
               exp.paid, exp.vend, exp.refund, exp.chg, exp.cv, exp.insuf, exp.rej, exp.busy);
    end
  endtask

  vec_t tbl[23];
  outs_t e;
  logic saw_refund;

  initial begin
    //            rst cv ct   b  c  price      paid     v  r  change   cv in rj bz
    tbl[0]  = mk(1, 0, 2'd0, 0, 0, 16'd0,   16'd0,   0, 0, 16'd0,  0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 2'd0, 0, 0, 16'd0,   16'd0,   0, 0, 16'd0,  0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 2'd0, 1, 0, 16'd10,  16'd0,   0, 0, 16'd0,  0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 2'd3, 0, 0, 16'd0,   16'd100, 0, 0, 16'd0,  0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 2'd2, 0, 0, 16'd0,   16'd150, 0, 0, 16'd0,  0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 2'd1, 0, 0, 16'd0,   16'd160, 0, 0, 16'd0,  0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 2'd0, 1, 0, 16'd130, 16'd160, 1, 0, 16'd30, 1, 0, 0, 1);
    tbl[7]  = mk(0, 0, 2'd0, 0, 0, 16'd0,   16'd0,   0, 0, 16'd30, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 2'd2, 0, 0, 16'd0,   16'd50,  0, 0, 16'd30, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 2'd0, 1, 0, 16'd200, 16'd50,  0, 0, 16'd30, 0, 1, 0, 0);
    tbl[10] = mk(0, 0, 2'd0, 0, 1, 16'd0,   16'd50,  0, 1, 16'd50, 1, 0, 0, 1);
    tbl[11] = mk(0, 1, 2'd0, 0, 0, 16'd0,   16'd0,   0, 0, 16'd50, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 2'd0, 0, 1, 16'd0,   16'd0,   0, 0, 16'd50, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 2'd2, 0, 0, 16'd0,   16'd50,  0, 0, 16'd50, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 2'd1, 0, 0, 16'd0,   16'd60,  0, 0, 16'd50, 0, 0, 0, 0);
    tbl[15] = mk(0, 1, 2'd0, 1, 1, 16'd10,  16'd60,  0, 1, 16'd60, 1, 0, 1, 1);
    tbl[16] = mk(0, 0, 2'd0, 0, 0, 16'd0,   16'd0,   0, 0, 16'd60, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 2'd0, 0, 0, 16'd0,   16'd5,   0, 0, 16'd60, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 2'd0, 1, 0, 16'd5,   16'd5,   1, 0, 16'd0,  1, 0, 0, 1);
    tbl[19] = mk(1, 1, 2'd3, 1, 1, 16'd0,   16'd0,   0, 0, 16'd0,  0, 0, 0, 0);
    tbl[20] = mk(0, 1, 2'd1, 1, 0, 16'd50,  16'd10,  0, 0, 16'd0,  0, 1, 0, 0);
    tbl[21] = mk(0, 1, 2'd3, 1, 0, 16'd10,  16'd10,  1, 0, 16'd0,  1, 0, 1, 1);
    tbl[22] = mk(0, 0, 2'd0, 1, 1, 16'd0,   16'd0,   0, 0, 16'd0,  0, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].cv, tbl[i].ct, tbl[i].buy, tbl[i].cancel, tbl[i].price);
      checkOutput($sformatf("row%0d", i), tbl[i].exp);
    end

    // Build credit to 16'hFFF0 (655 x 100 + 2 x 10), then probe the 16-bit ceiling
    for (int i = 0; i < 655; i++) applyStimulus(0, 1, 2'd3, 0, 0, 16'd0);
    applyStimulus(0, 1, 2'd1, 0, 0, 16'd0);
    applyStimulus(0, 1, 2'd1, 0, 0, 16'd0);
    e = '{paid: 16'hFFF0, vend: 0, refund: 0, chg: 16'd0, cv: 0, insuf: 0, rej: 0, busy: 0};
    checkOutput("fill_fff0", e);
    applyStimulus(0, 1, 2'd3, 0, 0, 16'd0);
    e.rej = 1;
    checkOutput("overflow_reject", e);
    applyStimulus(0, 1, 2'd1, 0, 0, 16'd0);
    e = '{paid: 16'hFFFA, vend: 0, refund: 0, chg: 16'd0, cv: 0, insuf: 0, rej: 0, busy: 0};
    checkOutput("fill_fffa", e);
    applyStimulus(0, 1, 2'd0, 0, 0, 16'd0);
    e.paid = 16'hFFFF;
    checkOutput("exact_ffff", e);
    applyStimulus(0, 1, 2'd0, 0, 0, 16'd0);
    e.rej = 1;
    checkOutput("ffff_plus5", e);
    applyStimulus(0, 0, 2'd0, 0, 1, 16'd0);
    e = '{paid: 16'hFFFF, vend: 0, refund: 1, chg: 16'hFFFF, cv: 1, insuf: 0, rej: 0, busy: 1};
    checkOutput("refund_ffff", e);
    applyStimulus(0, 0, 2'd0, 0, 0, 16'd0);
    e = '{paid: 16'd0, vend: 0, refund: 0, chg: 16'hFFFF, cv: 0, insuf: 0, rej: 0, busy: 0};
    checkOutput("after_refund", e);

    // Without the timeout macro, credit must sit in COLLECT indefinitely
    applyStimulus(0, 1, 2'd1, 0, 0, 16'd0);
    saw_refund = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      applyStimulus(0, 0, 2'd0, 0, 0, 16'd0);
      if (refund || change_valid) saw_refund = 1'b1;
    end
    e = '{paid: 16'd10, vend: 0, refund: 0, chg: 16'hFFFF, cv: 0, insuf: 0, rej: 0, busy: 0};
    checkOutput("no_timeout", e);
    vectors++;
    if (saw_refund) begin
      miscompares++;
      $display("[TB] FAIL no_timeout_pulse: got refund seen=1, want 0");
    end
    applyStimulus(0, 0, 2'd0, 0, 1, 16'd0);
    e = '{paid: 16'd10, vend: 0, refund: 1, chg: 16'd10, cv: 1, insuf: 0, rej: 0, busy: 1};
    checkOutput("late_cancel", e);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/payment_collector.md
PAYMENT_COLLECTOR -- requirements
Module: payment_collector

Interface
REQ-001 Parameter COIN_VAL0, default 5: credit value of coin_type 2'd0.
REQ-002 Parameter COIN_VAL1, default 10: credit value of coin_type 2'd1.
REQ-003 Parameter COIN_VAL2, default 50: credit value of coin_type 2'd2.
REQ-004 Parameter COIN_VAL3, default 100: credit value of coin_type 2'd3.
REQ-005 Parameter TIMEOUT_CYCLES, default 1000: idle cycles in COLLECT before auto-refund (used only when PAYMENT_TIMEOUT_EN is defined).
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 coin_valid  input  1  one coin presented this cycle.
REQ-009 coin_type  input  2  coin denomination; valid only with coin_valid.
REQ-010 buy  input  1  purchase request, sampled each cycle.
REQ-011 cancel  input  1  abort and refund request.
REQ-012 price_due  input  16  amount owed from pricing stage (discounted_price); sampled only in the buy cycle.
REQ-013 amount_paid  output  16  accumulated credit; feeds pricing stage amount_paid.
REQ-014 vend  output  1  one-cycle dispense pulse.
REQ-015 refund  output  1  one-cycle refund pulse.
REQ-016 change  output  16  coins to return; valid when change_valid.
REQ-017 change_valid  output  1  one-cycle qualifier for change.
REQ-018 insufficient  output  1  one-cycle pulse: buy rejected, credit too low.
REQ-019 coin_reject  output  1  one-cycle pulse: presented coin not credited.
REQ-020 busy  output  1  high in VEND or REFUND.

Function
REQ-021 FSM states IDLE, COLLECT, VEND, REFUND; all outputs registered, asserted cycle after triggering input edge.
REQ-022 IDLE: coin_valid -> amount_paid = coin value, go COLLECT; buy -> insufficient pulse, stay; cancel ignored.
REQ-023 COLLECT: coin_valid adds coin value to amount_paid.
REQ-024 Sum exceeding 16'hFFFF: coin not credited, coin_reject pulse, amount_paid unchanged.
REQ-025 COLLECT priority same cycle: cancel > buy > coin; coin losing priority -> coin_reject pulse, not credited.
REQ-026 COLLECT cancel -> REFUND.
REQ-027 COLLECT buy with amount_paid >= price_due: latch price_due, go VEND; otherwise insufficient pulse, stay COLLECT, credit kept.
REQ-028 VEND (one cycle): vend=1, change_valid=1, change = amount_paid - latched price (unsigned, never negative), then amount_paid=0, go IDLE.
REQ-029 REFUND (one cycle): refund=1, change_valid=1, change = amount_paid, then amount_paid=0, go IDLE.
REQ-030 busy states: coin_valid -> coin_reject pulse; buy and cancel ignored.
REQ-031 change holds last value between change_valid pulses; vend, refund, insufficient, coin_reject low except as specified.
REQ-032 buy to vend latency exactly 1 cycle; buy to IDLE return 2 cycles.

Reset
REQ-033 reset high at edge: state=IDLE, amount_paid=0, change=0, latched price=0, timeout counter=0, all pulse outputs and busy=0.
REQ-034 Reset overrides every input incl. mid-VEND/REFUND; accumulated credit discarded, no vend/refund pulse emitted.

Configuration
REQ-035 Macro PAYMENT_TIMEOUT_EN defined: counter increments each COLLECT cycle without credited coin, clears on credited coin or leaving COLLECT; reaching TIMEOUT_CYCLES -> REFUND (same as cancel).
REQ-036 Macro undefined: no counter, COLLECT waits indefinitely; all other behaviour identical.

Verification
REQ-037 Coins 100,50,10 (types 3,2,1) then buy, price_due=130 -> amount_paid 160; vend=1, change=30 next cycle; amount_paid=0 after.
REQ-038 Coin 50 then buy, price_due=200 -> insufficient pulse, amount_paid stays 50; cancel -> refund=1, change=50.
REQ-039 Credit 16'hFFF0, coin type 3 -> coin_reject pulse, amount_paid 16'hFFF0.
REQ-040 COLLECT credit 60, cancel+buy+coin same cycle -> REFUND change=60, coin_reject pulse, no vend.
REQ-041 Reset asserted in VEND cycle -> next cycle all outputs 0, state IDLE, no change_valid.
REQ-042 PAYMENT_TIMEOUT_EN, TIMEOUT_CYCLES=8, credit 10, no inputs -> refund, change=10 after 8 idle COLLECT cycles; macro undefined -> no refund.
